// File: rtl/mem_port_arbiter.sv
// Arbitrates the single SRAM master port between fetch (I) and load/store (D).
// D has fixed priority; a saturating starvation counter forces an I grant.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              sram_req,
  output logic              sram_we,
  output logic [1:0]        sram_size,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_ok,
  input  logic [DATA_W-1:0] sram_rdata
);

  // state  | meaning
  // IDLE   | no grant, arbitrating every cycle
  // BUSY_D | data requester owns the SRAM port
  // BUSY_I | fetch requester owns the SRAM port
  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [3:0] CNT_MAX = 4'd15;

  state_t            state;
  logic [3:0]        starve_cnt;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant_d;
  logic              grant_i;
  logic [1:0]        d_size_norm;

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (d_req && (!i_req || (starve_cnt < LIMIT))) grant_d = 1'b1;
      else if (i_req)                                grant_i = 1'b1;
    end
  end

  // Size 3 has no meaning on the bus; fold it onto a word access.
  assign d_size_norm = (d_size == 2'd3) ? 2'd2 : d_size;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      lat_we     <= 1'b0;
      lat_size   <= 2'd2;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      sram_req   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            sram_req  <= 1'b1;
            lat_we    <= d_we;
            lat_size  <= d_size_norm;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            if (i_req) starve_cnt <= (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + 4'd1;
            else       starve_cnt <= 4'd0;
          end else if (grant_i) begin
            state      <= BUSY_I;
            sram_req   <= 1'b1;
            lat_we     <= 1'b0;
            lat_size   <= 2'd2;
            lat_addr   <= i_addr;
            lat_wdata  <= '0;
            starve_cnt <= 4'd0;
          end
        end
        BUSY_D, BUSY_I: begin
          if (sram_ok) begin
            state    <= IDLE;
            sram_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          sram_req <= 1'b0;
        end
      endcase
    end
  end

  assign sram_we    = lat_we;
  assign sram_size  = lat_size;
  assign sram_addr  = lat_addr;
  assign sram_wdata = lat_wdata;

  // Completion is routed combinationally so a zero-wait SRAM finishes in one cycle.
  assign i_ok    = (state == BUSY_I) && sram_ok;
  assign d_ok    = (state == BUSY_D) && sram_ok;
  assign i_rdata = i_ok ? sram_rdata : '0;
  assign d_rdata = d_ok ? sram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants and
// completions, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_ok;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ok;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        sram_req, sram_we, sram_ok;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ok(i_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ok(d_ok), .d_rdata(d_rdata),
    .sram_req(sram_req), .sram_we(sram_we), .sram_size(sram_size),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ok(sram_ok), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gcyc;
  } gnt_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    int          lat;
  } cpl_t;

  gnt_t gq[$];
  cpl_t cq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ok_seen = 0;

  int          resp_lat = 0;
  logic [31:0] resp_rdata = '0;
  logic        stray_ok = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // SRAM model: answers after resp_lat wait cycles; stray_ok injects pulses while idle.
  initial begin : sram_model
    int wait_cnt;
    wait_cnt   = 0;
    sram_ok    = 1'b0;
    sram_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (sram_req && !sram_ok) begin
        if (wait_cnt >= resp_lat) begin
          sram_ok    = 1'b1;
          sram_rdata = resp_rdata;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        sram_ok    = stray_ok;
        sram_rdata = stray_ok ? 32'hFFFF_FFFF : 32'h0;
        wait_cnt   = 0;
      end
    end
  end

  // Monitor: pops a grant on each sram_req rise, checks it every busy cycle,
  // pops a completion on every ok pulse.
  initial begin : monitor
    gnt_t cur;
    cpl_t c;
    bit   have_cur;
    bit   prev_req;
    int   gnt_cyc;
    have_cur = 0;
    prev_req = 0;
    gnt_cyc  = 0;
    forever begin
      @(negedge clk);
      if (sram_req && !prev_req) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 64'(sram_addr), 64'hDEAD);
          have_cur = 0;
        end else begin
          cur      = gq.pop_front();
          have_cur = 1;
          gnt_cyc  = cyc;
          if (cur.gcyc >= 0) chk("grant_cycle", 64'(cyc), 64'(cur.gcyc));
        end
      end
      if (sram_req && have_cur) begin
        chk("sram_addr", 64'(sram_addr), 64'(cur.addr));
        chk("sram_wdata", 64'(sram_wdata), 64'(cur.wdata));
        chk("sram_we_size", 64'({sram_we, sram_size}), 64'({cur.we, cur.size}));
      end
      if (i_ok || d_ok) begin
        ok_seen++;
        if (cq.size() == 0) begin
          chk("unexpected_ok", 64'({d_ok, i_ok}), 64'd0);
        end else begin
          c = cq.pop_front();
          chk("ok_owner", 64'({d_ok, i_ok}), c.is_d ? 64'd2 : 64'd1);
          chk("ok_owner_matches_grant", 64'(c.is_d), 64'(cur.is_d));
          chk("ok_rdata", 64'(c.is_d ? d_rdata : i_rdata), 64'(c.rdata));
          chk("ok_latency", 64'(cyc - gnt_cyc), 64'(c.lat));
        end
      end
      prev_req = sram_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input bit is_d, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gcyc, input bit with_cpl,
                          input logic [31:0] rdata, input int lat);
    gnt_t g;
    cpl_t c;
    g.is_d = is_d; g.we = we; g.size = size; g.addr = addr; g.wdata = wdata; g.gcyc = gcyc;
    gq.push_back(g);
    if (with_cpl) begin
      c.is_d = is_d; c.rdata = rdata; c.lat = lat;
      cq.push_back(c);
    end
  endtask

  task automatic wait_oks(input int n, input string name);
    int target;
    bit done;
    target = ok_seen + n;
    done   = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      tick();
      if (ok_seen >= target) done = 1;
    end
    if (!done) chk({name, "_timeout"}, 64'(ok_seen), 64'(target));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_size = 2'd2; d_addr = '0; d_wdata = '0;

    // Reset values, then idle.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_sram_req", 64'(sram_req), 64'd0);
    chk("rst_sram_we", 64'(sram_we), 64'd0);
    chk("rst_sram_size", 64'(sram_size), 64'd2);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);
    chk("rst_sram_wdata", 64'(sram_wdata), 64'd0);
    chk("rst_oks", 64'({i_ok, d_ok}), 64'd0);
    chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_sram_req", 64'(sram_req), 64'd0);
      chk("idle_oks", 64'({i_ok, d_ok}), 64'd0);
      chk("idle_sram_size", 64'(sram_size), 64'd2);
    end

    // Single load, SRAM answers two cycles after the grant.
    tick();
    d_we = 0; d_size = 2'd2; d_addr = 32'h1000_0040; d_wdata = '0;
    resp_lat = 2; resp_rdata = 32'hDEAD_BEEF;
    push_txn(1, 0, 2'd2, 32'h1000_0040, 32'h0, cyc + 1, 1, 32'hDEAD_BEEF, 2);
    d_req = 1;
    wait_oks(1, "load");
    d_req = 0;

    // Both held high: expect D,D,D,D,I,D,D,D,D,I.
    tick();
    d_addr = 32'h0000_2000; d_wdata = '0; d_we = 0; d_size = 2'd2;
    i_addr = 32'h0000_0100;
    resp_lat = 0; resp_rdata = 32'h0BAD_F00D;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        push_txn(1, 0, 2'd2, 32'h0000_2000, 32'h0, -1, 1, 32'h0BAD_F00D, 0);
      push_txn(0, 0, 2'd2, 32'h0000_0100, 32'h0, -1, 1, 32'h0BAD_F00D, 0);
    end
    d_req = 1; i_req = 1;
    wait_oks(10, "starve");
    d_req = 0; i_req = 0;

    // Byte store with requester churn during the transaction.
    tick();
    d_we = 1; d_size = 2'd0; d_addr = 32'h3; d_wdata = 32'hA5;
    resp_lat = 3; resp_rdata = 32'h1111_2222;
    push_txn(1, 1, 2'd0, 32'h3, 32'hA5, cyc + 1, 1, 32'h1111_2222, 3);
    d_req = 1;
    tick();
    tick();
    d_addr = 32'h7; d_wdata = 32'hFF; d_size = 2'd2; d_we = 0;
    wait_oks(1, "store");
    d_req = 0;

    // Reset while fetch owns the port, then a stray sram_ok.
    tick();
    i_addr = 32'hBFC0_0000; resp_lat = 5;
    push_txn(0, 0, 2'd2, 32'hBFC0_0000, 32'h0, cyc + 1, 0, 32'h0, 0);
    i_req = 1;
    tick();
    tick();
    rst_n = 0; i_req = 0;
    tick();
    rst_n = 1; stray_ok = 1;
    @(negedge clk);
    chk("midrst_sram_req", 64'(sram_req), 64'd0);
    chk("midrst_oks", 64'({i_ok, d_ok}), 64'd0);
    tick();
    stray_ok = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_sram_req", 64'(sram_req), 64'd0);
      chk("post_rst_i_ok", 64'(i_ok), 64'd0);
    end

    // Stray sram_ok pulses while idle.
    for (int k = 0; k < 3; k++) begin
      tick();
      stray_ok = 1;
      @(negedge clk);
      chk("stray_oks", 64'({i_ok, d_ok}), 64'd0);
      tick();
      stray_ok = 0;
    end

    // Illegal size 3 becomes a word access.
    tick();
    d_we = 0; d_size = 2'd3; d_addr = 32'h44; d_wdata = 32'h77;
    resp_lat = 1; resp_rdata = 32'hCAFE_0001;
    push_txn(1, 0, 2'd2, 32'h44, 32'h77, cyc + 1, 1, 32'hCAFE_0001, 1);
    d_req = 1;
    wait_oks(1, "size3");
    d_req = 0;

    // Fetch alone with a zero-wait SRAM.
    tick();
    i_addr = 32'h0000_0200; resp_lat = 0; resp_rdata = 32'h0000_1234;
    push_txn(0, 0, 2'd2, 32'h0000_0200, 32'h0, cyc + 1, 1, 32'h0000_1234, 0);
    i_req = 1;
    wait_oks(1, "fetch");
    i_req = 0;

    repeat (3) tick();
    chk("grants_left", 64'(gq.size()), 64'd0);
    chk("completions_left", 64'(cq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single SRAM master port between the instruction-fetch requester (I) and the data/load-store requester (D).
- Accepts one transaction at a time and latches it for the SRAM side, then routes the completion pulse and read data back to the owning requester.
- Data has fixed priority over fetch, with a starvation guard so fetch is always eventually served.
- Sits between the fetch/LSU stages and the SRAM bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, max consecutive D grants while I is waiting before I is forced; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request; held until i_ok
- i_addr  in  ADDR_W  fetch address (always read, word size)
- i_ok  out  1  one-cycle completion pulse to fetch
- i_rdata  out  DATA_W  fetch data; valid only while i_ok=1
- d_req  in  1  data request; held until d_ok
- d_we  in  1  1 = store
- d_size  in  2  0 byte, 1 half, 2 word; 3 is illegal, treated as word
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ok  out  1  one-cycle completion pulse to data
- d_rdata  out  DATA_W  load data; valid only while d_ok=1
- sram_req  out  1  SRAM request
- sram_we  out  1  SRAM write enable
- sram_size  out  2  SRAM access size
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_ok  in  1  SRAM completion pulse; read data valid in the same cycle
- sram_rdata  in  DATA_W  SRAM read data

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to IDLE and starve_cnt=0.
  - All latched request registers clear.
  - sram_req=0, sram_we=0, sram_size=2, sram_addr=0, sram_wdata=0.
  - i_ok=0, d_ok=0, i_rdata=0, d_rdata=0.
- Reset mid-transaction abandons the transaction. No ok is issued, and a later stray sram_ok is ignored while in IDLE.
- FSM states:
  - IDLE: no grant.
  - BUSY_D: data owns the SRAM port.
  - BUSY_I: fetch owns the SRAM port.
- IDLE arbitration, evaluated every cycle:
  - d_req only -> BUSY_D.
  - i_req only -> BUSY_I.
  - Both requesting, starve_cnt < STARVE_LIMIT -> BUSY_D.
  - Both requesting, starve_cnt >= STARVE_LIMIT -> BUSY_I.
  - Neither requesting -> stay in IDLE.
  - On entry to a BUSY state, the winner's we/size/addr/wdata are latched. Fetch latches we=0 and size=2.
- starve_cnt:
  - Increments, saturating at 15, on a D grant while i_req=1.
  - Clears on any I grant.
  - Clears on a D grant while i_req=0.
- BUSY_x:
  - sram_req=1 and the sram_* outputs are driven from the latched registers.
  - These outputs are stable for the whole transaction regardless of requester input changes.
- Completion (BUSY_x and sram_ok=1):
  - The owner's x_ok=1 combinationally in the same cycle, and x_rdata=sram_rdata.
  - Next state is IDLE, and sram_req deasserts in the next cycle.
  - The non-owner's ok stays 0.
- The requester must drop req in the cycle after its ok. A req still high in IDLE is a new request.
- Latency:
  - Request seen in IDLE at cycle N -> sram_req=1 from cycle N+1.
  - A zero-wait SRAM (sram_ok in cycle N+1) gives x_ok in cycle N+1.
  - Best-case throughput is 1 transaction per 2 cycles.
- Ignored inputs:
  - sram_ok outside a BUSY state is ignored.
  - i_req/d_req changes during BUSY are ignored until the FSM returns to IDLE.
- The block performs no address alignment checking. That is the LSU's responsibility.

Test Plan:
- Reset then idle: both req=0 for 10 cycles -> sram_req=0 and all ok=0 throughout; sram_size=2.
- Single load: d_req=1, d_we=0, d_size=2, d_addr=0x1000_0040; SRAM returns sram_ok at N+3 with rdata=0xDEAD_BEEF -> sram_addr=0x1000_0040 from N+1; d_ok=1 and d_rdata=0xDEAD_BEEF only at N+3; i_ok=0.
- Simultaneous requests with STARVE_LIMIT=4: d_req and i_req held high continuously, D re-requests after each ok -> grant order D,D,D,D,I,D,D,D,D,I. starve_cnt reads 4 at the I grant, then 0.
- Byte store with input churn: d_req=1, d_we=1, d_size=0, d_addr=0x3, d_wdata=0xA5. d_addr changes to 0x7 during BUSY -> sram_addr stays 0x3 and sram_wdata stays 0xA5 until sram_ok.
- Reset mid-op: enter BUSY_I with i_addr=0xBFC0_0000, assert rst_n=0 for 1 cycle before sram_ok, then a stray sram_ok arrives -> FSM is IDLE, i_ok never pulses, sram_req=0 after reset.
- Stray and illegal inputs: sram_ok pulses in IDLE -> no ok. A D request with d_size=3 -> sram_size=2.
